rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and output stage for the 8-bit 2:1 mux datapath.
- Drives the mux select line from two valid/ready requesters (channel A = mux input a, channel B = mux input b).
- Captures the mux output `y` into a registered valid/ready output stream.
- Keeps per-channel saturating beat counters for coverage and debug.

---
 rtl/rr_mux_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for two valid/ready requesters feeding a 2:1 mux.
// The mux output is captured into a one-deep registered stream, and accepted beats are counted per channel.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    input  logic [WIDTH-1:0] mux_y,
    output logic [WIDTH-1:0] y_data,
    output logic             y_src,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q;
    state_t state_d;
    logic   last_grant_q;
    logic   grant;
    logic   slot_free;
    logic   fire;

    // Output stage state register and grant history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (fire) begin
                last_grant_q <= grant;
            end
        end
    end

    // Grant, handshake and next-state decode
    always_comb begin
        grant     = last_grant_q;
        slot_free = 1'b0;
        fire      = 1'b0;
        state_d   = state_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;

        unique case ({a_valid, b_valid})
            2'b11:   grant = ~last_grant_q;
            2'b10:   grant = 1'b0;
            2'b01:   grant = 1'b1;
            default: grant = last_grant_q;
        endcase

        slot_free = (state_q == EMPTY) || y_ready;

        // No handshake may complete while reset is being applied
        if (!rst) begin
            a_ready = slot_free && !grant;
            b_ready = slot_free && grant;
        end

        fire = (a_valid && a_ready) || (b_valid && b_ready);

        unique case (state_q)
            EMPTY: begin
                if (fire) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (y_ready && !fire) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign sel     = grant;
    assign y_valid = (state_q == FULL);

    // Output beat capture
    always_ff @(posedge clk) begin
        if (rst) begin
            y_data <= '0;
            y_src  <= 1'b0;
        end else if (fire) begin
            y_data <= mux_y;
            y_src  <= grant;
        end
    end

    // Saturating per-channel beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else if (fire) begin
            if (!grant && (a_count != CNT_MAX)) begin
                a_count <= a_count + CNT_W'(1);
            end
            if (grant && (b_count != CNT_MAX)) begin
                b_count <= b_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_rr_mux_arbiter;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid;
    logic             a_ready;
    logic             b_valid;
    logic             b_ready;
    logic             sel;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] y_data;
    logic             y_src;
    logic             y_valid;
    logic             y_ready;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_last;
    int m_full;
    int m_data;
    int m_src;
    int m_ac;
    int m_bc;

    rr_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .sel     (sel),
        .mux_y   (mux_y),
        .y_data  (y_data),
        .y_src   (y_src),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .a_count (a_count),
        .b_count (b_count)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b0;
        mux_y   = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Round-robin rule: contested -> whoever did not win last; single requester -> it; idle -> unchanged.
    function automatic int model_grant();
        if (a_valid && b_valid) return 1 - m_last;
        if (a_valid)            return 0;
        if (b_valid)            return 1;
        return m_last;
    endfunction

    function automatic int model_slot();
        return (m_full == 0 || y_ready) ? 1 : 0;
    endfunction

    task automatic model_step();
        int g;
        int accept;
        if (rst) begin
            m_last = 1; m_full = 0; m_data = 0; m_src = 0; m_ac = 0; m_bc = 0;
            return;
        end
        g      = model_grant();
        accept = (model_slot() == 1) && ((g == 0) ? a_valid : b_valid);
        if (accept) begin
            m_data = int'(mux_y);
            m_src  = g;
            m_full = 1;
            m_last = g;
            if (g == 0) m_ac = (m_ac < CNT_MAX) ? m_ac + 1 : m_ac;
            else        m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : m_bc;
        end else if (m_full == 1 && y_ready) begin
            m_full = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0; mux_y = 8'hEE;
        cycle();
        cycle();
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got %b expected 0", y_valid); end
        checks++; if (y_src !== 1'b0) begin failures++; $display("FAIL reset_y_src got %b expected 0", y_src); end
        checks++; if (y_data !== 8'h00) begin failures++; $display("FAIL reset_y_data got %h expected 00", y_data); end
        checks++; if (a_count !== 2'd0 || b_count !== 2'd0) begin failures++; $display("FAIL reset_counts got a=%0d b=%0d expected 0 0", a_count, b_count); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL reset_sel got %b expected 1", sel); end
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got a=%b b=%b expected 0 0", a_ready, b_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [7:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        do_reset();
        a_valid = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mux_y = vals[k];
            #1;
            checks++; if (sel !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL single_grant[%0d] got sel=%b ar=%b br=%b expected 0 1 0", k, sel, a_ready, b_ready); end
            cycle();
            checks++; if (y_valid !== 1'b1 || y_data !== vals[k] || y_src !== 1'b0) begin failures++; $display("FAIL single_data[%0d] got v=%b d=%h s=%b expected 1 %h 0", k, y_valid, y_data, y_src, vals[k]); end
        end
        a_valid = 1'b0;
        cycle();
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL single_drain got y_valid=%b expected 0", y_valid); end
        checks++; if (a_count !== 2'd3 || b_count !== 2'd0) begin failures++; $display("FAIL single_counts got a=%0d b=%0d expected 3 0", a_count, b_count); end
    endtask

    task automatic test_tie_round_robin();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mux_y = 8'(8'hA0 + k);
            #1;
            checks++; if (sel !== 1'(k % 2)) begin failures++; $display("FAIL tie_sel[%0d] got %b expected %0d", k, sel, k % 2); end
            cycle();
            checks++; if (y_src !== 1'(k % 2) || y_data !== 8'(8'hA0 + k)) begin failures++; $display("FAIL tie_out[%0d] got s=%b d=%h expected %0d %h", k, y_src, y_data, k % 2, 8'hA0 + k); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++; if (a_count !== 2'd2 || b_count !== 2'd2) begin failures++; $display("FAIL tie_counts got a=%0d b=%0d expected 2 2", a_count, b_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1'b1; y_ready = 1'b1; mux_y = 8'h5A;
        cycle();
        b_valid = 1'b1; y_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mux_y = 8'($urandom);
            #1;
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got a=%b b=%b expected 0 0", k, a_ready, b_ready); end
            cycle();
            checks++; if (y_valid !== 1'b1 || y_data !== 8'h5A || y_src !== 1'b0) begin failures++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%b expected 1 5a 0", k, y_valid, y_data, y_src); end
            checks++; if (a_count !== 2'd1 || b_count !== 2'd0) begin failures++; $display("FAIL bp_counts[%0d] got a=%0d b=%0d expected 1 0", k, a_count, b_count); end
        end
        y_ready = 1'b1; mux_y = 8'hC3;
        #1;
        checks++; if (sel !== 1'b1 || b_ready !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL bp_release got sel=%b ar=%b br=%b expected 1 0 1", sel, a_ready, b_ready); end
        cycle();
        checks++; if (y_data !== 8'hC3 || y_src !== 1'b1 || b_count !== 2'd1) begin failures++; $display("FAIL bp_accept got d=%h s=%b bc=%0d expected c3 1 1", y_data, y_src, b_count); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_a [5];
        exp_a = '{1, 2, 3, 3, 3};
        do_reset();
        a_valid = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mux_y = 8'(k);
            cycle();
            checks++; if (a_count !== CNT_W'(exp_a[k]) || b_count !== 2'd0) begin failures++; $display("FAIL sat_count[%0d] got a=%0d b=%0d expected %0d 0", k, a_count, b_count, exp_a[k]); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        a_valid = 1'b1; y_ready = 1'b1; mux_y = 8'h77;
        cycle();
        a_valid = 1'b0; y_ready = 1'b0;
        cycle();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h77) begin failures++; $display("FAIL mid_full got v=%b d=%h expected 1 77", y_valid, y_data); end
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1; mux_y = 8'h99;
        #1;
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got a=%b b=%b expected 0 0", a_ready, b_ready); end
        cycle();
        checks++; if (y_valid !== 1'b0 || a_count !== 2'd0 || b_count !== 2'd0) begin failures++; $display("FAIL mid_flush got v=%b a=%0d b=%0d expected 0 0 0", y_valid, a_count, b_count); end
        rst = 1'b0; mux_y = 8'h44;
        #1;
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL mid_first_tie got sel=%b expected 0", sel); end
        cycle();
        checks++; if (y_valid !== 1'b1 || y_src !== 1'b0 || y_data !== 8'h44) begin failures++; $display("FAIL mid_first_beat got v=%b s=%b d=%h expected 1 0 44", y_valid, y_src, y_data); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_random();
        int g;
        int exp_ar;
        int exp_br;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0; mux_y = '0;
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            a_valid = 1'($urandom_range(0, 3) != 0);
            b_valid = 1'($urandom_range(0, 2) != 0);
            y_ready = 1'($urandom_range(0, 3) != 0);
            mux_y   = 8'($urandom);
            #1;
            g      = model_grant();
            exp_ar = (!rst && model_slot() == 1 && g == 0) ? 1 : 0;
            exp_br = (!rst && model_slot() == 1 && g == 1) ? 1 : 0;
            checks++; if (sel !== 1'(g) || a_ready !== 1'(exp_ar) || b_ready !== 1'(exp_br)) begin failures++; $display("FAIL rand_comb[%0d] got sel=%b ar=%b br=%b expected %0d %0d %0d", i, sel, a_ready, b_ready, g, exp_ar, exp_br); end
            @(posedge clk);
            model_step();
            #1;
            checks++; if (y_valid !== 1'(m_full) || y_data !== 8'(m_data) || y_src !== 1'(m_src)) begin failures++; $display("FAIL rand_out[%0d] got v=%b d=%h s=%b expected %0d %h %0d", i, y_valid, y_data, y_src, m_full, m_data, m_src); end
            checks++; if (a_count !== CNT_W'(m_ac) || b_count !== CNT_W'(m_bc)) begin failures++; $display("FAIL rand_counts[%0d] got a=%0d b=%0d expected %0d %0d", i, a_count, b_count, m_ac, m_bc); end
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0; mux_y = '0;
        test_reset();
        test_single_channel();
        test_tie_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
